vec3_normalize: RTL and testbench
=================================

Name: vec3_normalize

Overview:
- Normalises signed Q8.24 3-vectors (ray directions, SDF gradient normals) for the ray marcher.
- Upstream half: computes the squared length and issues it to the inv_sqrt core (valid_in/x).
- Downstream half: consumes the inv_sqrt result (valid_out/inv_sqrt) and scales the buffered vector by it.
- A FIFO realigns each vector with its result, so any fixed inv_sqrt latency up to DEPTH-1 is tolerated.

Parameters:
- WIDTH, 32: data width of every vector component and of the inv_sqrt operands.
- FRAC, 24: number of fractional bits (Q8.24).
- DEPTH, 8: FIFO entries. Must be a power of two and at least inv_sqrt latency + 3.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector this cycle
- in_x, in_y, in_z  in  WIDTH each  signed Q8.24 components
- isq_valid  out  1  drives inv_sqrt valid_in
- isq_x  out  WIDTH  unsigned Q8.24 squared length; drives inv_sqrt x
- isq_res_valid  in  1  from inv_sqrt valid_out
- isq_res  in  WIDTH  unsigned Q8.24 value of 1/sqrt
- out_valid  out  1  normalised vector valid; single-cycle pulse, no backpressure
- out_x, out_y, out_z  out  WIDTH each  signed Q8.24 result
- err  out  1  sticky protocol error

Behaviour:
- Reset: every output register is 0 (isq_valid, isq_x, out_valid, out_*, err). FIFO is emptied. in_ready is 0 while rst is high and 1 from the first cycle after release.
- Accept: a vector is accepted when in_valid && in_ready. On acceptance the vector is pushed to the FIFO together with a zero flag (all three components equal 0).
- in_ready = (count != DEPTH). It does not look ahead to a same-cycle pop.
- Squared-length pipeline, 2 stages:
  - S1 registers three signed 2W-bit products, each shifted right by FRAC.
  - S2 adds them and saturates to unsigned 2^WIDTH-1, then registers isq_x and asserts isq_valid.
  - isq_valid is therefore asserted exactly 2 cycles after acceptance, one pulse per accepted vector, in order.
- Zero vector: isq_x=0 is still issued so result ordering is preserved.
- Result handling, when isq_res_valid is high:
  - FIFO empty: no pop, no out_valid, err is set and stays set until rst.
  - Otherwise pop the head and compute each component as signed comp × unsigned isq_res (signed 2W+1-bit), shifted right by FRAC, saturated to [0x80000000, 0x7FFFFFFF].
  - If the popped zero flag is set, out_x/y/z are forced to 0.
  - Results are registered, so out_valid is asserted 1 cycle after isq_res_valid.
- Simultaneous push and pop: count is unchanged, and head and tail pointers both advance and wrap modulo DEPTH.
- Reset mid-operation clears the pipeline valids, the FIFO and the output regs immediately. inv_sqrt shares rst, so no stale results arrive.
- Shifts truncate toward negative infinity unless the optional feature below is enabled.

Optional Feature:
- Macro: VEC3_NORM_ROUND_EN.
- Defined: every >>FRAC (squares and output scaling) rounds to nearest by adding 1<<(FRAC-1) before the shift. Saturation still applies after rounding.
- Undefined: plain arithmetic truncation.
- Latency is identical either way.

Decomposition:
- Package ray_pkg holds:
  - localparams Q_WIDTH=32 and Q_FRAC=24;
  - typedef q8_24_t (logic signed [31:0]);
  - typedef struct vec3_t {x,y,z};
  - typedef struct fifo_entry_t {vec3_t v; logic zero;}.
- One sub-module, sync_fifo (parameters: entry type width, DEPTH). It provides push, pop, head data, count, full and empty, with an async active-high reset.
- The squaring and scaling arithmetic stays in vec3_normalize.

Test Plan:
- Basic normalise: in = (0x03000000, 0x04000000, 0) → isq_x=0x19000000 two cycles later. Then drive isq_res=0x00333333 → next cycle out = (0x00999999, 0x00CCCCCC, 0x00000000) with the macro undefined.
- Zero vector: in = (0, 0, 0) → isq_x=0, isq_valid pulses. Then isq_res=0xFFFFFFFF → out = (0, 0, 0), out_valid=1.
- Saturation: in = (0x7F000000, 0x7F000000, 0x7F000000) → isq_x=0xFFFFFFFF. Then in = (0x80000000, 0, 0) with isq_res=0x02000000 (2.0) → out_x=0x80000000 (clamped).
- Full / backpressure (DEPTH=8):
  - Accept 8 back-to-back vectors with no results → in_ready=0 after the 8th.
  - One isq_res_valid → in_ready=1 on the next cycle, and a 9th vector is accepted.
- Ordering burst: 6 random vectors; a behavioural inv_sqrt model with 4-cycle latency returns results → 6 out_valid pulses, in input order, matching a reference model bit-exactly.
- Error and reset:
  - isq_res_valid with the FIFO empty → err=1, no out_valid.
  - Assert rst with 3 entries in flight → all outputs 0, err=0 and in_ready=0 during reset; in_ready=1 after release, and no outputs appear afterwards.

Source files
------------

// File: rtl/ray_pkg.sv
// Shared fixed-point and vector types for the ray marcher datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ray_pkg;

    localparam int Q_WIDTH = 32;
    localparam int Q_FRAC  = 24;

    typedef logic signed [Q_WIDTH-1:0] q8_24_t;

    typedef struct packed {
        q8_24_t x;
        q8_24_t y;
        q8_24_t z;
    } vec3_t;

    // Vector parked while its 1/sqrt is in flight; zero marks the null vector
    typedef struct packed {
        vec3_t v;
        logic  zero;
    } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head data, occupancy count and flags.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push ignored when full, pop ignored when empty.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];

    // Storage array is not reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vec3_normalize.sv
// Normalises Q8.24 3-vectors: squared length to inv_sqrt, scale the parked vector by the result.
// Latency: isq_valid 2 cycles after accept; out_valid 1 cycle after isq_res_valid.
// Backpressure: in_ready drops when the realignment FIFO is full; outputs have none.
// VEC3_NORM_ROUND_EN: when defined, every >>FRAC rounds to nearest instead of truncating.
module vec3_normalize
    import ray_pkg::*;
#(
    parameter int WIDTH = Q_WIDTH,
    parameter int FRAC  = Q_FRAC,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_x,
    input  logic signed [WIDTH-1:0] in_y,
    input  logic signed [WIDTH-1:0] in_z,
    output logic                    isq_valid,
    output logic [WIDTH-1:0]        isq_x,
    input  logic                    isq_res_valid,
    input  logic [WIDTH-1:0]        isq_res,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_x,
    output logic signed [WIDTH-1:0] out_y,
    output logic signed [WIDTH-1:0] out_z,
    output logic                    err
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

`ifdef VEC3_NORM_ROUND_EN
    localparam logic signed [PW-1:0] RND_SQ = PW'(1) << (FRAC - 1);
    localparam logic signed [PW:0]   RND_SC = (PW + 1)'(1) << (FRAC - 1);
`else
    localparam logic signed [PW-1:0] RND_SQ = '0;
    localparam logic signed [PW:0]   RND_SC = '0;
`endif

    localparam logic signed [PW:0] OUT_MAX = {{(WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [PW:0] OUT_MIN = {{(WIDTH + 2){1'b1}}, {(WIDTH - 1){1'b0}}};

    // Square of one component, rescaled to Q.FRAC; never negative
    function automatic logic [PW-1:0] square_q(input logic signed [WIDTH-1:0] c);
        logic signed [PW-1:0] e;
        logic signed [PW-1:0] s;
        e = PW'(c);
        s = (e * e + RND_SQ) >>> FRAC;
        return s;
    endfunction

    // Signed component times unsigned 1/sqrt, rescaled and clamped to the signed range
    function automatic logic [WIDTH-1:0] scale_q(input logic signed [WIDTH-1:0] c,
                                                 input logic [WIDTH-1:0]        r);
        logic signed [PW:0] ce;
        logic signed [PW:0] re;
        logic signed [PW:0] p;
        ce = (PW + 1)'(c);
        re = $signed({{(WIDTH + 1){1'b0}}, r});
        p  = (ce * re + RND_SC) >>> FRAC;
        if (p > OUT_MAX) begin
            return OUT_MAX[WIDTH-1:0];
        end else if (p < OUT_MIN) begin
            return OUT_MIN[WIDTH-1:0];
        end
        return p[WIDTH-1:0];
    endfunction

    fifo_entry_t   push_entry;
    fifo_entry_t   head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;

    logic          s1_valid;
    logic [PW-1:0] s1_x;
    logic [PW-1:0] s1_y;
    logic [PW-1:0] s1_z;
    logic [PW+1:0] sq_sum;
    logic [WIDTH-1:0] sq_sat;

    // Occupancy alone decides readiness; a same-cycle pop does not free a slot early
    assign in_ready  = !rst && (fifo_count != DEPTH_C);
    assign fifo_push = in_valid && in_ready && !fifo_full;
    assign fifo_pop  = isq_res_valid && !fifo_empty;

    assign push_entry.v.x  = in_x;
    assign push_entry.v.y  = in_y;
    assign push_entry.v.z  = in_z;
    assign push_entry.zero = (in_x == '0) && (in_y == '0) && (in_z == '0);

    sync_fifo #(
        .W     ($bits(fifo_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head_data (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Stage 1: per-component squares of the accepted vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_z     <= '0;
        end else begin
            s1_valid <= fifo_push;
            if (fifo_push) begin
                s1_x <= square_q(in_x);
                s1_y <= square_q(in_y);
                s1_z <= square_q(in_z);
            end
        end
    end

    // Sum of three non-negative squares, clamped to the unsigned operand range
    always_comb begin
        sq_sum = (PW + 2)'(s1_x) + (PW + 2)'(s1_y) + (PW + 2)'(s1_z);
        sq_sat = (|sq_sum[PW+1:WIDTH]) ? '1 : sq_sum[WIDTH-1:0];
    end

    // Stage 2: issue squared length to inv_sqrt, zero vectors included to keep order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            isq_valid <= 1'b0;
            isq_x     <= '0;
        end else begin
            isq_valid <= s1_valid;
            if (s1_valid) begin
                isq_x <= sq_sat;
            end
        end
    end

    // Result stage: scale the head vector, flag results that arrive with nothing parked
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
            err       <= 1'b0;
        end else begin
            out_valid <= fifo_pop;
            if (isq_res_valid && fifo_empty) begin
                err <= 1'b1;
            end
            if (fifo_pop) begin
                if (head.zero) begin
                    out_x <= '0;
                    out_y <= '0;
                    out_z <= '0;
                end else begin
                    out_x <= scale_q(head.v.x, isq_res);
                    out_y <= scale_q(head.v.y, isq_res);
                    out_z <= scale_q(head.v.z, isq_res);
                end
            end
        end
    end

endmodule

// File: tb/tb_vec3_normalize.sv
// Directed bench for vec3_normalize with a delayed behavioural inv_sqrt for the burst test.
// Inputs driven 1 time unit after posedge; outputs sampled at the same point.
// Summary line reports the number of comparisons and failures.
module tb_vec3_normalize;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_x = '0;
    logic [31:0] in_y = '0;
    logic [31:0] in_z = '0;
    logic        isq_valid;
    logic [31:0] isq_x;
    logic        isq_res_valid;
    logic [31:0] isq_res;
    logic        out_valid;
    logic [31:0] out_x;
    logic [31:0] out_y;
    logic [31:0] out_z;
    logic        err;

    logic        drv_res_valid = 1'b0;
    logic [31:0] drv_res = '0;
    logic        model_en = 1'b0;
    logic [3:0]  mv;
    logic [31:0] mr [4];

    int checks = 0;
    int errors = 0;

`ifdef VEC3_NORM_ROUND_EN
    localparam longint RND = 64'sd8388608;
`else
    localparam longint RND = 64'sd0;
`endif

    always #5 clk = ~clk;

    vec3_normalize dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_x          (in_x),
        .in_y          (in_y),
        .in_z          (in_z),
        .isq_valid     (isq_valid),
        .isq_x         (isq_x),
        .isq_res_valid (isq_res_valid),
        .isq_res       (isq_res),
        .out_valid     (out_valid),
        .out_x         (out_x),
        .out_y         (out_y),
        .out_z         (out_z),
        .err           (err)
    );

    function automatic logic [31:0] inv_sqrt_model(input logic [31:0] x);
        real v;
        if (x == 32'd0) return 32'hFFFF_FFFF;
        v = 16777216.0 / $sqrt(real'(x) / 16777216.0);
        if (v >= 4294967295.0) return 32'hFFFF_FFFF;
        return 32'(longint'(v));
    endfunction

    function automatic longint ref_sq(input logic [31:0] a);
        longint e;
        e = longint'($signed(a));
        return (e * e + RND) >>> 24;
    endfunction

    function automatic logic [31:0] ref_isq(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
        longint s;
        s = ref_sq(a) + ref_sq(b) + ref_sq(c);
        if (s > 64'sd4294967295) return 32'hFFFF_FFFF;
        return 32'(s);
    endfunction

    function automatic logic [31:0] ref_scale(input logic [31:0] c, input logic [31:0] r);
        longint p;
        p = longint'($signed(c)) * longint'(r);
        p = (p + RND) >>> 24;
        if (p > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (p < -64'sd2147483648) return 32'h8000_0000;
        return 32'(p);
    endfunction

    // Behavioural inv_sqrt: fixed 4-register delay from isq_valid
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mv <= '0;
            for (int i = 0; i < 4; i++) mr[i] <= '0;
        end else begin
            mv    <= {mv[2:0], isq_valid};
            mr[0] <= inv_sqrt_model(isq_x);
            mr[1] <= mr[0];
            mr[2] <= mr[1];
            mr[3] <= mr[2];
        end
    end

    assign isq_res_valid = model_en ? mv[3] : drv_res_valid;
    assign isq_res       = model_en ? mr[3] : drv_res;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_vec(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        in_z = z;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_res(input logic [31:0] r);
        drv_res_valid = 1'b1;
        drv_res = r;
        tick();
        drv_res_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        checks++;
        if ({isq_valid, isq_x} !== 33'd0) begin
            errors++; $display("FAIL reset_isq: got %b/%h expected 0/0", isq_valid, isq_x);
        end
        checks++;
        if ({out_valid, out_x, out_y, out_z} !== 97'd0) begin
            errors++; $display("FAIL reset_out: got %b %h %h %h expected zeros", out_valid, out_x, out_y, out_z);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b expected 0", err);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        send_vec(32'h0300_0000, 32'h0400_0000, 32'h0);
        checks++;
        if (isq_valid !== 1'b0) begin
            errors++; $display("FAIL basic_isq_early: got %b expected 0", isq_valid);
        end
        tick();
        checks++;
        if (isq_valid !== 1'b1 || isq_x !== 32'h1900_0000) begin
            errors++; $display("FAIL basic_isq: got %b/%h expected 1/19000000", isq_valid, isq_x);
        end
        tick();
        checks++;
        if (isq_valid !== 1'b0) begin
            errors++; $display("FAIL basic_isq_pulse: got %b expected 0", isq_valid);
        end
        send_res(32'h0033_3333);
        checks++;
        if (out_valid !== 1'b1 || out_x !== 32'h0099_9999 || out_y !== 32'h00CC_CCCC || out_z !== 32'h0) begin
            errors++; $display("FAIL basic_out: got %b %h %h %h expected 1 00999999 00cccccc 00000000",
                               out_valid, out_x, out_y, out_z);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_out_pulse: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_zero();
        send_vec(32'h0, 32'h0, 32'h0);
        tick();
        checks++;
        if (isq_valid !== 1'b1 || isq_x !== 32'h0) begin
            errors++; $display("FAIL zero_isq: got %b/%h expected 1/00000000", isq_valid, isq_x);
        end
        tick();
        send_res(32'hFFFF_FFFF);
        checks++;
        if (out_valid !== 1'b1 || {out_x, out_y, out_z} !== 96'd0) begin
            errors++; $display("FAIL zero_out: got %b %h %h %h expected 1 0 0 0", out_valid, out_x, out_y, out_z);
        end
    endtask

    task automatic test_saturation();
        send_vec(32'h7F00_0000, 32'h7F00_0000, 32'h7F00_0000);
        tick();
        checks++;
        if (isq_valid !== 1'b1 || isq_x !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL sat_isq: got %b/%h expected 1/ffffffff", isq_valid, isq_x);
        end
        send_vec(32'h8000_0000, 32'h0, 32'h0);
        tick();
        checks++;
        if (isq_valid !== 1'b1 || isq_x !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL sat_isq_neg: got %b/%h expected 1/ffffffff", isq_valid, isq_x);
        end
        send_res(32'h0200_0000);
        checks++;
        if (out_valid !== 1'b1 || out_x !== 32'h7FFF_FFFF || out_y !== 32'h7FFF_FFFF || out_z !== 32'h7FFF_FFFF) begin
            errors++; $display("FAIL sat_out_pos: got %b %h %h %h expected 1 7fffffff x3", out_valid, out_x, out_y, out_z);
        end
        send_res(32'h0200_0000);
        checks++;
        if (out_valid !== 1'b1 || out_x !== 32'h8000_0000 || out_y !== 32'h0 || out_z !== 32'h0) begin
            errors++; $display("FAIL sat_out_neg: got %b %h %h %h expected 1 80000000 0 0", out_valid, out_x, out_y, out_z);
        end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_x = 32'(i) << 24;
            in_y = 32'h0;
            in_z = 32'h0;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL full_ready_%0d: got %b expected 1", i, in_ready);
            end
            tick();
        end
        in_x = 32'h0900_0000;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL full_ready_after_8: got %b expected 0", in_ready);
        end
        tick();
        drv_res_valid = 1'b1;
        drv_res = 32'h0100_0000;
        tick();
        drv_res_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_x !== 32'h0100_0000 || in_ready !== 1'b1) begin
            errors++; $display("FAIL full_pop: got out %b %h ready %b expected 1 01000000 ready 1",
                               out_valid, out_x, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL full_ninth_accept: got ready %b expected 0", in_ready);
        end
        for (int i = 2; i <= 9; i++) begin
            send_res(32'h0100_0000);
            checks++;
            if (out_valid !== 1'b1 || out_x !== (32'(i) << 24)) begin
                errors++; $display("FAIL full_drain_%0d: got %b %h expected 1 %h", i, out_valid, out_x, 32'(i) << 24);
            end
        end
    endtask

    task automatic test_error();
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_before: got %b expected 0", err);
        end
        send_res(32'h0100_0000);
        checks++;
        if (out_valid !== 1'b0 || err !== 1'b1) begin
            errors++; $display("FAIL err_empty_pop: got out_valid %b err %b expected 0 1", out_valid, err);
        end
        tick();
        tick();
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL err_sticky: got %b expected 1", err);
        end
    endtask

    task automatic test_ordering();
        logic [31:0] vx [6];
        logic [31:0] vy [6];
        logic [31:0] vz [6];
        logic [31:0] ex [6];
        logic [31:0] ey [6];
        logic [31:0] ez [6];
        logic [31:0] r;
        int n;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            vx[i] = (i == 3) ? 32'h0 : 32'($signed($urandom()) >>> 4);
            vy[i] = (i == 3) ? 32'h0 : 32'($signed($urandom()) >>> 4);
            vz[i] = (i == 3) ? 32'h0 : 32'($signed($urandom()) >>> 4);
            r = inv_sqrt_model(ref_isq(vx[i], vy[i], vz[i]));
            ex[i] = (i == 3) ? 32'h0 : ref_scale(vx[i], r);
            ey[i] = (i == 3) ? 32'h0 : ref_scale(vy[i], r);
            ez[i] = (i == 3) ? 32'h0 : ref_scale(vz[i], r);
        end
        model_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_x = vx[i];
            in_y = vy[i];
            in_z = vz[i];
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (n >= 6) begin
                    errors++; $display("FAIL order_extra: got pulse %0d expected only 6", n);
                end else if (out_x !== ex[n] || out_y !== ey[n] || out_z !== ez[n]) begin
                    errors++; $display("FAIL order_vec_%0d: got %h %h %h expected %h %h %h",
                                       n, out_x, out_y, out_z, ex[n], ey[n], ez[n]);
                end
                n++;
            end
            tick();
        end
        checks++;
        if (n != 6) begin
            errors++; $display("FAIL order_count: got %0d pulses expected 6", n);
        end
        model_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_x = 32'(i + 1) << 24;
            in_y = 32'h0100_0000;
            in_z = 32'h0;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({isq_valid, isq_x, out_valid, out_x, out_y, out_z} !== 130'd0) begin
            errors++; $display("FAIL midrst_outputs: got %b %h %b %h %h %h expected zeros",
                               isq_valid, isq_x, out_valid, out_x, out_y, out_z);
        end
        checks++;
        if (err !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_err_ready: got err %b ready %b expected 0 0", err, in_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_release_ready: got %b expected 1", in_ready);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            if (isq_valid === 1'b1 || out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL midrst_stale: got %0d cycles with output activity expected 0", seen);
        end
        send_res(32'h0100_0000);
        checks++;
        if (out_valid !== 1'b0 || err !== 1'b1) begin
            errors++; $display("FAIL midrst_fifo_cleared: got out_valid %b err %b expected 0 1", out_valid, err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_saturation();
        test_full();
        test_error();
        test_ordering();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
